rcc_clkdiv_multi: RTL

- Multi-channel programmable clock divider for the RCC block; the next generation of the single-channel half-ratio divider.
- Generates CHANNELS independent divided clocks from one REF_CLK.
- Each channel has its own shadowed ratio, applied glitch-free at the channel's period boundary.
- Each channel has a synchronous enable/park, a bypass mode, and a per-period TICK pulse for downstream clock-enable use.

---
 rtl/rcc_clkdiv_multi.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rcc_clkdiv_multi.sv
// ============================================================================
// Module   : rcc_clkdiv_multi
// Brief    : Multi-channel programmable clock divider with shadowed ratios,
//            glitch-free ratio changes, enable/park, bypass and per-period TICK.
//            Optional macro CLKDIV_ODD_DUTY50_EN adds a negedge stage per channel
//            for 50% duty on odd ratios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rcc_clkdiv_multi #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int DEFAULT_RATIO = 2
) (
    input  logic                      REF_CLK,
    input  logic                      RST,
    input  logic [CHANNELS*WIDTH-1:0] DIV_RATIO,
    input  logic [CHANNELS-1:0]       DIV_LOAD,
    input  logic [CHANNELS-1:0]       DIV_EN,
    output logic [CHANNELS-1:0]       OUT_CLK,
    output logic [CHANNELS-1:0]       TICK,
    output logic [CHANNELS-1:0]       LOAD_PENDING
);

    localparam logic [WIDTH-1:0] c_def_ratio = WIDTH'(DEFAULT_RATIO);
    localparam logic [WIDTH-1:0] c_min_div   = WIDTH'(2);

    // High-phase length in REF_CLK cycles; one extra bit keeps R = 2^WIDTH-1 safe.
    function automatic logic [WIDTH:0] high_cnt(input logic [WIDTH-1:0] r);
`ifdef CLKDIV_ODD_DUTY50_EN
        high_cnt = {1'b0, r} >> 1;
`else
        high_cnt = ({1'b0, r} + {{WIDTH{1'b0}}, r[0]}) >> 1;
`endif
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [WIDTH-1:0] ratio_q, ratio_d;
        logic [WIDTH-1:0] shadow_q, shadow_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             pending_q, pending_d;
        logic             running_q, running_d;
        logic             div_q, div_d;
        logic             tick_q, tick_d;
        logic             w_bypass;
        logic             w_boundary;
        logic [WIDTH-1:0] w_r_next;
        logic             w_div_out;

        always_comb begin
            w_bypass   = (ratio_q < c_min_div);
            w_boundary = w_bypass | ~running_q | (cnt_q == (ratio_q - WIDTH'(1)));
            // A load on a boundary edge lands in shadow after the old shadow is applied.
            w_r_next   = (w_boundary & pending_q) ? shadow_q : ratio_q;

            ratio_d    = w_r_next;
            shadow_d   = DIV_LOAD[g] ? DIV_RATIO[g*WIDTH +: WIDTH] : shadow_q;
            pending_d  = DIV_LOAD[g] | (pending_q & ~w_boundary);
            running_d  = running_q;
            cnt_d      = cnt_q;
            div_d      = div_q;

            if (w_boundary) begin
                if (DIV_EN[g] && (w_r_next >= c_min_div)) begin
                    running_d = 1'b1;
                    cnt_d     = '0;
                    div_d     = 1'b1;
                end else begin
                    running_d = 1'b0;
                    cnt_d     = '0;
                    div_d     = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
                div_d = ({1'b0, cnt_d} < high_cnt(ratio_q));
            end

            tick_d = running_d & (cnt_d == '0);
        end

        always_ff @(posedge REF_CLK or posedge RST) begin
            if (RST) begin
                ratio_q   <= c_def_ratio;
                shadow_q  <= c_def_ratio;
                cnt_q     <= '0;
                pending_q <= 1'b0;
                running_q <= 1'b0;
                div_q     <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                ratio_q   <= ratio_d;
                shadow_q  <= shadow_d;
                cnt_q     <= cnt_d;
                pending_q <= pending_d;
                running_q <= running_d;
                div_q     <= div_d;
                tick_q    <= tick_d;
            end
        end

`ifdef CLKDIV_ODD_DUTY50_EN
        logic div_n_q, div_n_d;

        always_comb begin
            div_n_d = div_q;
        end

        // Half-cycle delayed copy stretches odd-ratio high phase by half a REF_CLK.
        always_ff @(negedge REF_CLK or posedge RST) begin
            if (RST) begin
                div_n_q <= 1'b0;
            end else begin
                div_n_q <= div_n_d;
            end
        end

        assign w_div_out = ratio_q[0] ? (div_q | div_n_q) : div_q;
`else
        assign w_div_out = div_q;
`endif

        assign OUT_CLK[g]      = w_bypass ? (REF_CLK & DIV_EN[g]) : w_div_out;
        assign TICK[g]         = w_bypass ? DIV_EN[g] : tick_q;
        assign LOAD_PENDING[g] = pending_q;
    end

endmodule

`default_nettype wire
